// File: rtl/reg_access_pkg.sv
// Shared constants for the register access arbiter: FSM encoding and default sizes.
package reg_access_pkg;

  localparam int DEF_NREG = 8;
  localparam int DEF_AW   = 3;
  localparam int DEF_DW   = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot winner plus the last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       prio0,
  input  logic       advance,
  output logic [1:0] win
);

  logic lastM1;

  // m0 wins when alone, when forced, or on a tie after m1 was served last.
  always_comb begin
    win = 2'b00;
    if (req[0] && (prio0 || !req[1] || lastM1)) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lastM1 <= 1'b1;
    end else if (advance && (|win)) begin
      lastM1 <= win[1];
    end
  end

endmodule

// File: rtl/reg_access_arb.sv
// Two-master arbiter in front of NREG registers; IDLE -> ACCESS -> DONE per access.
// Optional bus lock for m0 is enabled with the REG_ACCESS_ARB_LOCK_EN macro.
module reg_access_arb
  import reg_access_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic               clk,
  input  logic               rstn,
`ifdef REG_ACCESS_ARB_LOCK_EN
  input  logic               m0_lock,
`endif
  input  logic               m0_req,
  input  logic               m0_wr,
  input  logic [AW-1:0]      m0_addr,
  input  logic [DW-1:0]      m0_wdata,
  output logic               m0_gnt,
  output logic               m0_ack,
  output logic               m0_err,
  output logic [DW-1:0]      m0_rdata,
  input  logic               m1_req,
  input  logic               m1_wr,
  input  logic [AW-1:0]      m1_addr,
  input  logic [DW-1:0]      m1_wdata,
  output logic               m1_gnt,
  output logic               m1_ack,
  output logic               m1_err,
  output logic [DW-1:0]      m1_rdata,
  output logic [NREG-1:0]    reg_wr,
  output logic [DW-1:0]      reg_wdata,
  input  logic [NREG*DW-1:0] reg_rdata
);

  logic [1:0]      state;
  logic            owner;
  logic            latWr;
  logic [AW-1:0]   latAddr;
  logic            errFlag;
  logic [DW-1:0]   m0Rd;
  logic [DW-1:0]   m1Rd;
  logic [1:0]      win;
  logic            prio0;
  logic [NREG-1:0] addrHit;
  logic [DW-1:0]   rdSel;

`ifdef REG_ACCESS_ARB_LOCK_EN
  assign prio0 = m0_lock;
`else
  assign prio0 = 1'b0;
`endif

  rr_arb2 uArb (
    .clk     (clk),
    .rstn    (rstn),
    .req     ({m1_req, m0_req}),
    .prio0   (prio0),
    .advance (state == IDLE),
    .win     (win)
  );

  // NOTE: defaults first so no path through the loop leaves a latch behind.
  always_comb begin
    addrHit = '0;
    rdSel   = '0;
    for (int i = 0; i < NREG; i++) begin
      if (latAddr == AW'(i)) begin
        addrHit[i] = 1'b1;
        rdSel      = reg_rdata[i*DW +: DW];
      end
    end
  end

  // NOTE: read holding registers are reset too, so a master never sees stale data after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      latWr     <= 1'b0;
      latAddr   <= '0;
      reg_wdata <= '0;
      errFlag   <= 1'b0;
      m0Rd      <= '0;
      m1Rd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|win) begin
            owner     <= win[1];
            latWr     <= win[1] ? m1_wr    : m0_wr;
            latAddr   <= win[1] ? m1_addr  : m0_addr;
            reg_wdata <= win[1] ? m1_wdata : m0_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          errFlag <= ~|addrHit;
          // rdSel is already zero for an out-of-range address.
          if (!latWr || !(|addrHit)) begin
            if (owner) m1Rd <= rdSel;
            else       m0Rd <= rdSel;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_gnt   = (state == IDLE) && win[0];
  assign m1_gnt   = (state == IDLE) && win[1];
  assign m0_ack   = (state == DONE) && !owner;
  assign m1_ack   = (state == DONE) &&  owner;
  assign m0_err   = m0_ack && errFlag;
  assign m1_err   = m1_ack && errFlag;
  assign m0_rdata = m0Rd;
  assign m1_rdata = m1Rd;
  assign reg_wr   = ((state == ACCESS) && latWr) ? addrHit : '0;

endmodule

// File: tb/tb_reg_access_arb.sv
// Directed bench for reg_access_arb: cycle table plus reset, out-of-range and lock sequences.
module tb_reg_access_arb;

  localparam logic [31:0] W  = 32'h1234_5678;
  localparam logic [31:0] C  = 32'hCAFE_F00D;
  localparam logic [31:0] S1 = 32'h1111_1111;
  localparam logic [31:0] D  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [2:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  reg_wr;
  logic [31:0] reg_wdata;
  logic [255:0] reg_rdata;
`ifdef REG_ACCESS_ARB_LOCK_EN
  logic        m0_lock;
`endif

  // Second instance with NREG=6 for the out-of-range address case.
  logic        s_req, s_wr;
  logic [2:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt, s_ack, s_err, s1_gnt, s1_ack, s1_err;
  logic [31:0] s_rdata, s1_rdata;
  logic [5:0]  s_regWr;
  logic [31:0] s_regWdata;
  logic [191:0] s_regRdata;

  int nCompared = 0;
  int nMismatched = 0;

  reg_access_arb dut (
    .clk(clk), .rstn(rstn),
`ifdef REG_ACCESS_ARB_LOCK_EN
    .m0_lock(m0_lock),
`endif
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  reg_access_arb #(.NREG(6), .AW(3), .DW(32)) dut6 (
    .clk(clk), .rstn(rstn),
`ifdef REG_ACCESS_ARB_LOCK_EN
    .m0_lock(1'b0),
`endif
    .m0_req(s_req), .m0_wr(s_wr), .m0_addr(s_addr), .m0_wdata(s_wdata),
    .m0_gnt(s_gnt), .m0_ack(s_ack), .m0_err(s_err), .m0_rdata(s_rdata),
    .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(3'd0), .m1_wdata(32'd0),
    .m1_gnt(s1_gnt), .m1_ack(s1_ack), .m1_err(s1_err), .m1_rdata(s1_rdata),
    .reg_wr(s_regWr), .reg_wdata(s_regWdata), .reg_rdata(s_regRdata)
  );

  typedef struct {
    logic        req0, wr0; logic [2:0] addr0; logic [31:0] wd0;
    logic        req1, wr1; logic [2:0] addr1; logic [31:0] wd1;
    logic        gnt0, gnt1, ack0, ack1, err0, err1;
    logic [7:0]  regWr; logic [31:0] regWd;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row order: req0,wr0,addr0,wd0, req1,wr1,addr1,wd1, gnt0,gnt1,ack0,ack1,err0,err1, regWr,regWd, rd0,rd1
    tbl[0]  = '{0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 8'h00,0, 0,0};
    tbl[1]  = '{1,1,2,W, 0,0,0,0,   1,0,0,0,0,0, 8'h00,0, 0,0};
    tbl[2]  = '{0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 8'h04,W, 0,0};
    tbl[3]  = '{0,0,0,0, 0,0,0,0,   0,0,1,0,0,0, 8'h00,0, 0,0};
    tbl[4]  = '{0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 8'h00,0, 0,0};
    tbl[5]  = '{0,0,0,0, 1,0,5,0,   0,1,0,0,0,0, 8'h00,0, 0,0};
    tbl[6]  = '{0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 8'h00,0, 0,0};
    tbl[7]  = '{0,0,0,0, 0,0,0,0,   0,0,0,1,0,0, 8'h00,0, 0,C};
    tbl[8]  = '{0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 8'h00,0, 0,C};
    tbl[9]  = '{1,0,1,0, 1,1,3,D,   1,0,0,0,0,0, 8'h00,0, 0,C};
    tbl[10] = '{1,0,1,0, 1,1,3,D,   0,0,0,0,0,0, 8'h00,0, 0,C};
    tbl[11] = '{1,0,1,0, 1,1,3,D,   0,0,1,0,0,0, 8'h00,0, S1,C};
    tbl[12] = '{1,0,1,0, 1,1,3,D,   0,1,0,0,0,0, 8'h00,0, S1,C};
    tbl[13] = '{1,0,1,0, 1,1,3,D,   0,0,0,0,0,0, 8'h08,D, S1,C};
    tbl[14] = '{1,0,1,0, 1,1,3,D,   0,0,0,1,0,0, 8'h00,0, S1,C};
    tbl[15] = '{1,0,1,0, 1,1,3,D,   1,0,0,0,0,0, 8'h00,0, S1,C};
    tbl[16] = '{1,0,1,0, 1,1,3,D,   0,0,0,0,0,0, 8'h00,0, S1,C};
    tbl[17] = '{1,0,1,0, 1,1,3,D,   0,0,1,0,0,0, 8'h00,0, S1,C};
    tbl[18] = '{1,0,1,0, 1,1,3,D,   0,1,0,0,0,0, 8'h00,0, S1,C};
    tbl[19] = '{1,0,1,0, 1,1,3,D,   0,0,0,0,0,0, 8'h08,D, S1,C};
    tbl[20] = '{1,0,1,0, 1,1,3,D,   0,0,0,1,0,0, 8'h00,0, S1,C};
    tbl[21] = '{0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 8'h00,0, S1,C};

    for (int i = 0; i < 8; i++) reg_rdata[i*32 +: 32] = 32'(i) * S1;
    reg_rdata[5*32 +: 32] = C;
    s_regRdata = '0;
    s_regRdata[3*32 +: 32] = 32'h3333_3333;

    rstn = 0;
    idleInputs();
    s_req = 0; s_wr = 0; s_addr = 0; s_wdata = 0;
`ifdef REG_ACCESS_ARB_LOCK_EN
    m0_lock = 0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst gnt", {m0_gnt, m1_gnt}, 0);
    check("rst ack", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("rst reg_wr", reg_wr, 0);
    check("rst reg_wdata", reg_wdata, 0);
    check("rst rdata", {m0_rdata, m1_rdata}, 0);
    @(negedge clk);
    rstn = 1;

    // Single write, single read, then alternating round-robin traffic
    for (int i = 0; i < 22; i++) begin
      cyc();
      m0_req = tbl[i].req0; m0_wr = tbl[i].wr0; m0_addr = tbl[i].addr0; m0_wdata = tbl[i].wd0;
      m1_req = tbl[i].req1; m1_wr = tbl[i].wr1; m1_addr = tbl[i].addr1; m1_wdata = tbl[i].wd1;
      #1;
      check($sformatf("row%0d gnt", i), {m0_gnt, m1_gnt}, {tbl[i].gnt0, tbl[i].gnt1});
      check($sformatf("row%0d ack", i), {m0_ack, m1_ack}, {tbl[i].ack0, tbl[i].ack1});
      check($sformatf("row%0d err", i), {m0_err, m1_err}, {tbl[i].err0, tbl[i].err1});
      check($sformatf("row%0d reg_wr", i), reg_wr, tbl[i].regWr);
      if (tbl[i].regWr != 0) check($sformatf("row%0d reg_wdata", i), reg_wdata, tbl[i].regWd);
      check($sformatf("row%0d rdata0", i), m0_rdata, tbl[i].rd0);
      check($sformatf("row%0d rdata1", i), m1_rdata, tbl[i].rd1);
    end

    // NREG=6: in-range read, then write to addr 7 clears rdata and flags err
    cyc(); s_req = 1; s_wr = 0; s_addr = 3; #1;
    check("n6 rd gnt", s_gnt, 1);
    cyc(); s_req = 0; #1;
    check("n6 rd reg_wr", s_regWr, 0);
    cyc(); #1;
    check("n6 rd ack/err", {s_ack, s_err}, 2'b10);
    check("n6 rd rdata", s_rdata, 32'h3333_3333);
    cyc(); s_req = 1; s_wr = 1; s_addr = 7; s_wdata = 32'hAAAA_5555; #1;
    check("n6 oor gnt", s_gnt, 1);
    cyc(); s_req = 0; #1;
    check("n6 oor reg_wr", s_regWr, 0);
    cyc(); #1;
    check("n6 oor ack/err", {s_ack, s_err}, 2'b11);
    check("n6 oor rdata", s_rdata, 0);
    check("n6 oor reg_wr done", s_regWr, 0);
    cyc(); #1;
    check("n6 after ack/err", {s_ack, s_err}, 2'b00);

    // Reset in the middle of a write
    cyc(); m0_req = 1; m0_wr = 1; m0_addr = 4; m0_wdata = 32'h55; #1;
    check("abort gnt", m0_gnt, 1);
    cyc(); m0_req = 0; #1;
    check("abort reg_wr pre", reg_wr, 8'h10);
    #1; rstn = 0; #1;
    check("abort reg_wr now", reg_wr, 0);
    cyc();
    check("abort no ack", {m0_ack, reg_wr}, 0);
    @(negedge clk); rstn = 1;
    cyc(); #1;
    check("abort idle", {m0_ack, m0_gnt, reg_wr}, 0);
    // Pointer back at m1, so m0 takes the tie
    cyc();
    m0_req = 1; m0_wr = 1; m0_addr = 6; m0_wdata = 32'h66;
    m1_req = 1; m1_wr = 0; m1_addr = 0;
    #1;
    check("post-rst tie gnt", {m0_gnt, m1_gnt}, 2'b10);
    cyc(); idleInputs(); #1;
    check("post-rst reg_wr", reg_wr, 8'h40);
    check("post-rst reg_wdata", reg_wdata, 32'h66);
    cyc(); #1;
    check("post-rst ack", {m0_ack, m1_ack, m0_err}, 3'b100);

`ifdef REG_ACCESS_ARB_LOCK_EN
    // Last grant was m0, so only the lock can give m0 the next ties
    for (int k = 0; k < 3; k++) begin
      cyc(); m0_lock = 1; m0_req = 1; m0_wr = 0; m0_addr = 0; m1_req = 1; m1_wr = 0; m1_addr = 0; #1;
      check($sformatf("lock%0d gnt", k), {m0_gnt, m1_gnt}, 2'b10);
      cyc(); cyc(); #1;
      check($sformatf("lock%0d ack", k), {m0_ack, m1_ack}, 2'b10);
    end
    cyc(); m0_lock = 0; #1;
    check("unlock gnt", {m0_gnt, m1_gnt}, 2'b01);
    cyc(); idleInputs(); cyc(); #1;
    check("unlock ack", {m0_ack, m1_ack}, 2'b01);
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
